// File: rtl/key_scan_module.sv
// key_scan_module: three-key synchroniser and debouncer.
// Emits a clean level plus press, release and long-press pulses per key.
//
// Ports:
//   CLK         system clock
//   RST         asynchronous active-high reset
//   Key_In      raw button pins, asynchronous to CLK
//   Key_State   debounced level, 1 = pressed
//   Key_Press   1-cycle pulse on accepted press
//   Key_Release 1-cycle pulse on accepted release
//   Key_Long    1-cycle pulse once per press after LONG_CYCLES held
module key_scan_module #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] Key_In,
  output logic [2:0] Key_State,
  output logic [2:0] Key_Press,
  output logic [2:0] Key_Release,
  output logic [2:0] Key_Long
);

  localparam int MAXC = (DEBOUNCE_CYCLES > LONG_CYCLES) ?
                        DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;

  // The first accepting sample loads 0, so the D-th consecutive
  // sample is seen with the counter at D-2 (same for the long count).
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] LG_LAST = CW'(LONG_CYCLES - 2);
  localparam logic [CW-1:0] LG_SAT  = CW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    DOWN,
    RELEASE_WAIT
  } state_t;

  logic [2:0] k;
  logic [2:0] s1;
  logic [2:0] s2;

  assign k = Key_In ^ {3{KEY_ACTIVE_LOW}};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= k;
      s2 <= s1;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_key
    state_t          st;
    logic [CW-1:0]   dcnt;
    logic [CW-1:0]   lcnt;
    logic            fired;
    logic            lvl;
    logic            pr;
    logic            rl;
    logic            lg;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        st    <= IDLE;
        dcnt  <= '0;
        lcnt  <= '0;
        fired <= 1'b0;
        lvl   <= 1'b0;
        pr    <= 1'b0;
        rl    <= 1'b0;
        lg    <= 1'b0;
      end else begin
        pr <= 1'b0;
        rl <= 1'b0;
        lg <= 1'b0;
        unique case (st)
          IDLE: begin
            if (s2[gi]) begin
              st   <= PRESS_WAIT;
              dcnt <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!s2[gi]) begin
              st <= IDLE;
            end else if (dcnt == DB_LAST) begin
              st   <= DOWN;
              lvl  <= 1'b1;
              pr   <= 1'b1;
              dcnt <= '0;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
          DOWN: begin
            if (lcnt != LG_SAT) begin
              lcnt <= lcnt + 1'b1;
            end
            if (lcnt == LG_LAST && !fired) begin
              lg    <= 1'b1;
              fired <= 1'b1;
            end
            if (!s2[gi]) begin
              st   <= RELEASE_WAIT;
              dcnt <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (s2[gi]) begin
              st <= DOWN;
            end else if (dcnt == DB_LAST) begin
              st    <= IDLE;
              lvl   <= 1'b0;
              rl    <= 1'b1;
              dcnt  <= '0;
              lcnt  <= '0;
              fired <= 1'b0;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end

    assign Key_State[gi]   = lvl;
    assign Key_Press[gi]   = pr;
    assign Key_Release[gi] = rl;
    assign Key_Long[gi]    = lg;
  end

endmodule

// File: tb/tb_key_scan_module.sv
// tb_key_scan_module: table, directed and random checks
// of key_scan_module against a run-length reference model.
module tb_key_scan_module;

  localparam int D = 8;
  localparam int L = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] key_in = 3'b111;
  logic [2:0] st;
  logic [2:0] pr;
  logic [2:0] rl;
  logic [2:0] lg;

  always #5 clk = ~clk;

  key_scan_module #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .Key_In(key_in),
    .Key_State(st),
    .Key_Press(pr),
    .Key_Release(rl),
    .Key_Long(lg)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a 2-deep delay line for the synchroniser,
  // then per key a run length of samples disagreeing with the
  // accepted level and a hold time counted while firmly down.
  logic [2:0] m_d0, m_d1;
  logic [2:0] m_acc, m_p, m_r, m_l;
  int m_run[3];
  int m_hold[3];

  task automatic model_reset();
    m_d0 = '0;
    m_d1 = '0;
    m_acc = '0;
    m_p = '0;
    m_r = '0;
    m_l = '0;
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0;
      m_hold[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [2:0] kin);
    logic [2:0] samp;
    samp = m_d1;
    m_d1 = m_d0;
    m_d0 = ~kin;
    m_p = '0;
    m_r = '0;
    m_l = '0;
    for (int i = 0; i < 3; i++) begin
      if (!m_acc[i]) begin
        m_run[i] = samp[i] ? m_run[i] + 1 : 0;
        if (m_run[i] == D) begin
          m_acc[i] = 1'b1;
          m_p[i] = 1'b1;
          m_run[i] = 0;
          m_hold[i] = 0;
        end
      end else begin
        if (m_run[i] == 0 && m_hold[i] < L) begin
          m_hold[i]++;
          if (m_hold[i] == L - 1) m_l[i] = 1'b1;
        end
        m_run[i] = samp[i] ? 0 : m_run[i] + 1;
        if (m_run[i] == D) begin
          m_acc[i] = 1'b0;
          m_r[i] = 1'b1;
          m_run[i] = 0;
          m_hold[i] = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [2:0] es,
                       input logic [2:0] ep, input logic [2:0] er,
                       input logic [2:0] el);
    vectors++;
    if ({st, pr, rl, lg} !== {es, ep, er, el}) begin
      miscompares++;
      $display("FAIL %s t=%0t: got st=%b pr=%b rl=%b lg=%b, want st=%b pr=%b rl=%b lg=%b",
               name, $time, st, pr, rl, lg, es, ep, er, el);
    end
  endtask

  task automatic step(input logic [2:0] kin, input string name);
    key_in = kin;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(kin);
    #1;
    check(name, m_acc, m_p, m_r, m_l);
  endtask

  typedef struct {
    logic [2:0] kin;
    int         len;
    logic [2:0] es;
    logic [2:0] ep;
    logic [2:0] er;
    logic [2:0] el;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [2:0] cur;
    int p;

    // clean press/release on key 0
    tbl.push_back('{3'b110,  9, 3'b000, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b110,  1, 3'b001, 3'b001, 3'b000, 3'b000});
    tbl.push_back('{3'b110, 30, 3'b001, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b111,  9, 3'b001, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b111,  1, 3'b000, 3'b000, 3'b001, 3'b000});
    tbl.push_back('{3'b111,  3, 3'b000, 3'b000, 3'b000, 3'b000});
    // long press on key 2
    tbl.push_back('{3'b011,  9, 3'b000, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b011,  1, 3'b100, 3'b100, 3'b000, 3'b000});
    tbl.push_back('{3'b011, 18, 3'b100, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b011,  1, 3'b100, 3'b000, 3'b000, 3'b100});
    tbl.push_back('{3'b011, 31, 3'b100, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b111,  9, 3'b100, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b111,  1, 3'b000, 3'b000, 3'b100, 3'b000});
    tbl.push_back('{3'b111,  3, 3'b000, 3'b000, 3'b000, 3'b000});
    // parallel keys, then key 1 released alone
    tbl.push_back('{3'b000,  9, 3'b000, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b000,  1, 3'b111, 3'b111, 3'b000, 3'b000});
    tbl.push_back('{3'b000,  5, 3'b111, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b010,  9, 3'b111, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b010,  1, 3'b101, 3'b000, 3'b010, 3'b000});
    tbl.push_back('{3'b010,  3, 3'b101, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b111,  9, 3'b101, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b111,  1, 3'b000, 3'b000, 3'b101, 3'b000});
    tbl.push_back('{3'b111,  3, 3'b000, 3'b000, 3'b000, 3'b000});
    // 5-cycle release glitch while key 0 is down
    tbl.push_back('{3'b110, 10, 3'b001, 3'b001, 3'b000, 3'b000});
    tbl.push_back('{3'b110,  3, 3'b001, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b111,  5, 3'b001, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b110,  8, 3'b001, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b111,  9, 3'b001, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b111,  1, 3'b000, 3'b000, 3'b001, 3'b000});
    tbl.push_back('{3'b111,  3, 3'b000, 3'b000, 3'b000, 3'b000});

    model_reset();

    // reset held 5 cycles, then 100 idle cycles
    for (int i = 0; i < 5; i++) begin
      step(3'b111, "in_reset");
      check("reset_zero", 3'b000, 3'b000, 3'b000, 3'b000);
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) step(3'b111, "idle");
    check("idle_zero", 3'b000, 3'b000, 3'b000, 3'b000);

    foreach (tbl[r]) begin
      for (int j = 0; j < tbl[r].len; j++) step(tbl[r].kin, "tbl_model");
      check($sformatf("tbl_row%0d", r), tbl[r].es, tbl[r].ep,
            tbl[r].er, tbl[r].el);
    end

    // key 1 bounces every 3 cycles: never accepted
    for (int i = 0; i < 45; i++) begin
      step((i < 30 && (i / 3) % 2 == 0) ? 3'b101 : 3'b111, "bounce");
      vectors++;
      if (st[1] !== 1'b0 || pr[1] !== 1'b0 || rl[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce i=%0d: got st=%b pr=%b rl=%b, want all 0 on key 1",
                 i, st[1], pr[1], rl[1]);
      end
    end

    // async reset while key 0 is held down
    for (int i = 0; i < 12; i++) step(3'b110, "pre_rst");
    check("held_down", 3'b001, 3'b000, 3'b000, 3'b000);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst", 3'b000, 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) step(3'b110, "rst_hold");
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(3'b110, "reheld");
      if (i == 9)
        check("reheld_quiet", 3'b000, 3'b000, 3'b000, 3'b000);
      if (i == 10)
        check("reheld_press", 3'b001, 3'b001, 3'b000, 3'b000);
    end
    for (int i = 0; i < 12; i++) step(3'b111, "post_rst");

    // random stimulus: fast chatter, then slower changes
    cur = 3'b111;
    for (int n = 0; n < 3000; n++) begin
      p = (n < 1200) ? 4 : 24;
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, p - 1) == 0) cur[b] = ~cur[b];
      rst = ($urandom_range(0, 599) == 0);
      step(cur, "random");
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step(3'b111, "drain");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
